// File: rtl/psram_arbiter_pkg.sv
// Shared constants and types for the PSRAM two-client arbiter.
package psram_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 21;
    localparam int unsigned DATA_W_DEF       = 64;
    localparam int unsigned MASK_W_DEF       = 8;
    localparam int unsigned BURST_WORDS_DEF  = 4;
    localparam int unsigned CMD_INTERVAL_DEF = 14;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/psram_arbiter.sv
// Round-robin read/write arbiter in front of the Gowin PSRAM HS IP.
// One burst command at a time, with a fixed minimum command spacing.
module psram_arbiter
    import psram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MASK_W       = MASK_W_DEF,
    parameter int unsigned BURST_WORDS  = BURST_WORDS_DEF,
    parameter int unsigned CMD_INTERVAL = CMD_INTERVAL_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_write_req,
    output logic              o_write_gnt,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic [MASK_W-1:0] i_write_data_mask,
    input  logic              i_read_req,
    output logic              o_read_gnt,
    input  logic [ADDR_W-1:0] i_read_addr,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_read_data_valid,
    input  logic              i_psram_init_calib,
    output logic              o_psram_cmd,
    output logic              o_psram_cmd_en,
    output logic [ADDR_W-1:0] o_psram_addr,
    output logic [DATA_W-1:0] o_psram_wr_data,
    output logic [MASK_W-1:0] o_psram_data_mask,
    input  logic [DATA_W-1:0] i_psram_rd_data,
    input  logic              i_psram_rd_data_valid
);

    localparam int unsigned CNT_W = $clog2(CMD_INTERVAL + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;        // cycles since the last cmd_en
    logic                last_wr_q, last_wr_d; // 1 = write was granted last
    logic                cmd_en_q, cmd_en_d;
    logic                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_gnt_q, write_gnt_d;
    logic                read_gnt_q, read_gnt_d;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                pick_write;

    // Next-state: winner selection in IDLE, burst/spacing countdown elsewhere.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_wr_d   = last_wr_q;
        cmd_en_d    = 1'b0;
        cmd_d       = CMD_READ;
        addr_d      = '0;
        write_gnt_d = 1'b0;
        read_gnt_d  = 1'b0;
        pick_write  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_psram_init_calib && (i_write_req || i_read_req)) begin
                    // On a tie, grant whichever client did not win last time.
                    pick_write = i_write_req && (!i_read_req || !last_wr_q);
                    cmd_en_d   = 1'b1;
                    cnt_d      = '0;
                    last_wr_d  = pick_write;
                    if (pick_write) begin
                        write_gnt_d = 1'b1;
                        cmd_d       = CMD_WRITE;
                        addr_d      = i_write_addr;
                        state_d     = WRITE;
                    end else begin
                        read_gnt_d  = 1'b1;
                        cmd_d       = CMD_READ;
                        addr_d      = i_read_addr;
                        state_d     = WAIT;
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CMD_INTERVAL - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return path: hold the last beat while valid is low.
    always_comb begin
        rd_data_d = i_psram_rd_data_valid ? i_psram_rd_data : rd_data_q;
    end

    // State, counter and registered command/grant outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_wr_q   <= 1'b1;
            cmd_en_q    <= 1'b0;
            cmd_q       <= 1'b0;
            addr_q      <= '0;
            write_gnt_q <= 1'b0;
            read_gnt_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_wr_q   <= last_wr_d;
            cmd_en_q    <= cmd_en_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            write_gnt_q <= write_gnt_d;
            read_gnt_q  <= read_gnt_d;
            rd_valid_q  <= i_psram_rd_data_valid;
            rd_data_q   <= rd_data_d;
        end
    end

    // Write beats pass straight through only while a write burst is active.
    always_comb begin
        o_psram_wr_data   = '0;
        o_psram_data_mask = '0;
        if (state_q == WRITE) begin
            o_psram_wr_data   = i_write_data;
            o_psram_data_mask = i_write_data_mask;
        end
    end

    assign o_psram_cmd_en    = cmd_en_q;
    assign o_psram_cmd       = cmd_q;
    assign o_psram_addr      = addr_q;
    assign o_write_gnt       = write_gnt_q;
    assign o_read_gnt        = read_gnt_q;
    assign o_read_data_valid = rd_valid_q;
    assign o_read_data       = rd_data_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter.
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_req = 1'b0;
    logic        write_gnt;
    logic [20:0] write_addr = '0;
    logic [63:0] write_data = '0;
    logic [7:0]  write_mask = '0;
    logic        read_req = 1'b0;
    logic        read_gnt;
    logic [20:0] read_addr = '0;
    logic [63:0] read_data;
    logic        read_valid;
    logic        calib = 1'b0;
    logic        cmd;
    logic        cmd_en;
    logic [20:0] paddr;
    logic [63:0] pwr_data;
    logic [7:0]  pmask;
    logic [63:0] prd_data = '0;
    logic        prd_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psram_arbiter dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_write_req           (write_req),
        .o_write_gnt           (write_gnt),
        .i_write_addr          (write_addr),
        .i_write_data          (write_data),
        .i_write_data_mask     (write_mask),
        .i_read_req            (read_req),
        .o_read_gnt            (read_gnt),
        .i_read_addr           (read_addr),
        .o_read_data           (read_data),
        .o_read_data_valid     (read_valid),
        .i_psram_init_calib    (calib),
        .o_psram_cmd           (cmd),
        .o_psram_cmd_en        (cmd_en),
        .o_psram_addr          (paddr),
        .o_psram_wr_data       (pwr_data),
        .o_psram_data_mask     (pmask),
        .i_psram_rd_data       (prd_data),
        .i_psram_rd_data_valid (prd_valid)
    );

    // Advance on falling edges until cmd_en is seen or the budget runs out.
    task automatic wait_cmd(input int bound, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (cmd_en) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_en got %b want 0", cmd_en); end
        checks++; if (write_gnt !== 1'b0) begin errors++; $display("FAIL reset_wgnt got %b want 0", write_gnt); end
        checks++; if (read_gnt !== 1'b0) begin errors++; $display("FAIL reset_rgnt got %b want 0", read_gnt); end
        checks++; if (paddr !== 21'd0) begin errors++; $display("FAIL reset_addr got %h want 0", paddr); end
        checks++; if (pwr_data !== 64'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", pwr_data); end
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", read_valid); end
        checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data); end
    endtask

    task automatic test_no_calib();
        int bad;
        bad = 0;
        rst_n = 1'b1;
        calib = 1'b0;
        write_req = 1'b1;
        read_req = 1'b1;
        write_addr = 21'h1234;
        read_addr = 21'h0777;
        write_data = 64'hffff_0000_ffff_0000;
        write_mask = 8'hff;
        repeat (100) begin
            @(negedge clk);
            if (cmd_en || write_gnt || read_gnt || cmd || paddr != 0 || pwr_data != 0 || pmask != 0)
                bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL no_calib_activity got %0d want 0", bad); end
    endtask

    task automatic test_read();
        int t0, t1;
        bit ok;
        write_req = 1'b0;
        read_req = 1'b1;
        read_addr = 21'h00100;
        @(negedge clk);
        calib = 1'b1;
        wait_cmd(10, t0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_cmd_timeout got none want cmd_en"); end
        checks++; if (read_gnt !== 1'b1) begin errors++; $display("FAIL read_gnt got %b want 1", read_gnt); end
        checks++; if (write_gnt !== 1'b0) begin errors++; $display("FAIL read_wgnt got %b want 0", write_gnt); end
        checks++; if (cmd !== 1'b0) begin errors++; $display("FAIL read_cmd got %b want 0", cmd); end
        checks++; if (paddr !== 21'h00100) begin errors++; $display("FAIL read_addr got %h want 00100", paddr); end
        @(negedge clk);
        checks++; if (read_gnt !== 1'b0 || cmd_en !== 1'b0) begin
            errors++; $display("FAIL read_pulse got gnt=%b en=%b want 0 0", read_gnt, cmd_en);
        end
        wait_cmd(40, t1, ok);
        checks++; if (!ok || (t1 - t0) < 15) begin
            errors++; $display("FAIL read_spacing got %0d want >=15", t1 - t0);
        end
        read_req = 1'b0;
    endtask

    task automatic test_write();
        int t0;
        bit ok;
        logic [63:0] base;
        base = 64'h0123_4567_89ab_cdef;
        write_req = 1'b1;
        write_addr = 21'd12345;
        write_data = base;
        write_mask = 8'h5a;
        wait_cmd(40, t0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_cmd_timeout got none want cmd_en"); end
        checks++; if (write_gnt !== 1'b1 || cmd !== 1'b1) begin
            errors++; $display("FAIL write_gnt_cmd got gnt=%b cmd=%b want 1 1", write_gnt, cmd);
        end
        checks++; if (paddr !== 21'd12345) begin errors++; $display("FAIL write_addr got %0d want 12345", paddr); end
        checks++; if (pwr_data !== base || pmask !== 8'h5a) begin
            errors++; $display("FAIL write_beat0 got %h/%h want %h/5a", pwr_data, pmask, base);
        end
        write_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            write_data = base + 64'(k);
            #1;
            checks++; if (pwr_data !== base + 64'(k) || pmask !== 8'h5a) begin
                errors++; $display("FAIL write_beat%0d got %h/%h want %h/5a", k, pwr_data, pmask, base + 64'(k));
            end
        end
        @(negedge clk);
        #1;
        checks++; if (pwr_data !== 64'd0 || pmask !== 8'd0) begin
            errors++; $display("FAIL write_after_burst got %h/%h want 0/0", pwr_data, pmask);
        end
    endtask

    task automatic test_round_robin();
        int prev, t;
        bit ok;
        bit exp_wr;
        read_addr = 21'h00aaa;
        write_addr = 21'h00bbb;
        read_req = 1'b1;
        write_req = 1'b1;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            exp_wr = (n % 2) == 1;
            wait_cmd(40, t, ok);
            checks++; if (!ok || write_gnt !== exp_wr || read_gnt !== !exp_wr) begin
                errors++; $display("FAIL rr_grant%0d got w=%b r=%b want w=%b", n, write_gnt, read_gnt, exp_wr);
            end
            checks++; if (paddr !== (exp_wr ? 21'h00bbb : 21'h00aaa)) begin
                errors++; $display("FAIL rr_addr%0d got %h", n, paddr);
            end
            if (n > 0) begin
                checks++; if (t - prev !== 15) begin
                    errors++; $display("FAIL rr_spacing%0d got %0d want 15", n, t - prev);
                end
            end
            prev = t;
        end
        read_req = 1'b0;
        write_req = 1'b0;
    endtask

    task automatic test_read_return();
        @(negedge clk);
        prd_valid = 1'b1;
        prd_data = 64'ha0;
        #1;
        checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL rret_early got %b want 0", read_valid); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (read_valid !== 1'b1 || read_data !== 64'ha0 + 64'(k - 1)) begin
                errors++; $display("FAIL rret_beat%0d got %b/%h want 1/%h", k - 1, read_valid, read_data, 64'ha0 + 64'(k - 1));
            end
            if (k < 4) prd_data = 64'ha0 + 64'(k);
            else begin prd_valid = 1'b0; prd_data = 64'hff; end
        end
        @(negedge clk);
        checks++; if (read_valid !== 1'b0 || read_data !== 64'ha3) begin
            errors++; $display("FAIL rret_hold got %b/%h want 0/a3", read_valid, read_data);
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        bit ok;
        write_req = 1'b1;
        write_data = 64'hdead_beef_0000_1111;
        write_mask = 8'h0f;
        wait_cmd(40, t, ok);
        checks++; if (!ok || write_gnt !== 1'b1) begin errors++; $display("FAIL rmid_wgnt got %b want 1", write_gnt); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwr_data !== 64'd0 || pmask !== 8'd0) begin
            errors++; $display("FAIL rmid_wr_data got %h/%h want 0/0", pwr_data, pmask);
        end
        checks++; if (cmd_en !== 1'b0 || write_gnt !== 1'b0 || paddr !== 21'd0) begin
            errors++; $display("FAIL rmid_outputs got en=%b g=%b a=%h want 0", cmd_en, write_gnt, paddr);
        end
        read_req = 1'b1;
        read_addr = 21'h00321;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cmd(10, t, ok);
        checks++; if (!ok || read_gnt !== 1'b1 || write_gnt !== 1'b0) begin
            errors++; $display("FAIL rmid_read_first got r=%b w=%b want 1 0", read_gnt, write_gnt);
        end
        checks++; if (paddr !== 21'h00321) begin errors++; $display("FAIL rmid_addr got %h want 00321", paddr); end
        read_req = 1'b0;
        write_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_calib();
        test_read();
        test_write();
        test_round_robin();
        test_read_return();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-requester arbiter between a framebuffer read client and a write client, in front of the Gowin PSRAM HS memory-interface IP.
- Runs entirely in the PSRAM IP's user clock (clk_out domain).
- Issues one burst command at a time, enforces the IP's minimum command spacing, forwards write-burst data and returns read data to the read client.

Parameters:
- ADDR_W, 21, PSRAM word address width.
- DATA_W, 64, user data width.
- MASK_W, 8, byte-mask width (DATA_W/8).
- BURST_WORDS, 4, data beats per command (burst 16 on the x32 dual-channel IP).
- CMD_INTERVAL, 14, minimum cycles from one o_psram_cmd_en to the next (must be greater than BURST_WORDS).

Ports:
- i_clk  in  1  PSRAM user clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_write_req  in  1  write request level.
- o_write_gnt  out  1  one-cycle write grant pulse.
- i_write_addr  in  ADDR_W  write burst start address.
- i_write_data  in  DATA_W  current write beat.
- i_write_data_mask  in  MASK_W  current beat byte mask (1 = byte not written).
- i_read_req  in  1  read request level.
- o_read_gnt  out  1  one-cycle read grant pulse.
- i_read_addr  in  ADDR_W  read burst start address.
- o_read_data  out  DATA_W  read beat.
- o_read_data_valid  out  1  read beat valid.
- i_psram_init_calib  in  1  IP calibration done.
- o_psram_cmd  out  1  1 = write, 0 = read.
- o_psram_cmd_en  out  1  command strobe.
- o_psram_addr  out  ADDR_W  command address.
- o_psram_wr_data  out  DATA_W  write data to IP.
- o_psram_data_mask  out  MASK_W  write mask to IP.
- i_psram_rd_data  in  DATA_W  read data from IP.
- i_psram_rd_data_valid  in  1  read data valid from IP.

Behaviour:
- Reset: all outputs 0; state IDLE; interval counter 0; last-granted flag = write, so read wins the first tie.
- No grant is ever issued while i_psram_init_calib = 0; requests are held off, not dropped.
- States:
  - IDLE: on a clock edge where calib = 1 and at least one request is high, select a winner. Next cycle (registered) raise the winner's gnt, o_psram_cmd_en, o_psram_cmd and o_psram_addr (the address latched from the winner at selection) for exactly one cycle. Move to WRITE if write won, else WAIT.
  - WRITE: lasts BURST_WORDS cycles, starting with the cmd_en cycle. o_psram_wr_data = i_write_data and o_psram_data_mask = i_write_data_mask combinationally. The write client presents beat 0 while requesting and advances one beat per cycle after gnt. Afterwards go to WAIT.
  - WAIT: hold until CMD_INTERVAL cycles have elapsed since cmd_en, then return to IDLE. A new command may be selected on the IDLE edge, so the next cmd_en is at least CMD_INTERVAL+1 cycles later.
- Outside WRITE, o_psram_wr_data = 0 and o_psram_data_mask = 0.
- Arbitration when both requests are high: round-robin; grant the client not granted last. A single requester is granted in every slot.
- Requests are levels. A requester still high after its gnt is treated as a new request.
- Read return: o_read_data and o_read_data_valid are i_psram_rd_data and i_psram_rd_data_valid registered once (1-cycle latency), regardless of state.
- o_read_data holds its last value when valid is low.
- Calib dropping mid-burst: the current burst and WAIT complete normally; further grants stop.
- Async reset mid-burst: everything returns to reset values immediately, and the burst is abandoned.

Decomposition:
- Shared package: ADDR_W, DATA_W, MASK_W, BURST_WORDS, CMD_INTERVAL defaults; command encodings CMD_READ = 0 and CMD_WRITE = 1; state enum {IDLE, WRITE, WAIT}.
- No sub-module needed; one flat module.

Test Plan:
- Reset, then calib = 0 with both requests high for 100 cycles -> no gnt, no cmd_en, all outputs 0.
- Calib = 1, read_req with addr 0x00100 -> one read_gnt cycle coincident with cmd_en = 1, cmd = 0, addr 0x00100; next cmd_en no earlier than CMD_INTERVAL+1 cycles later.
- write_req, addr 12345, data 0x0123_4567_89ab_cdef, mask 0x5a held -> write_gnt with cmd = 1 and addr 12345; wr_data and mask follow the input for exactly 4 cycles from cmd_en, then return to 0.
- Both requests held continuously -> grants alternate read, write, read, write; spacing exactly CMD_INTERVAL+1 cycles.
- Inject rd_data_valid for 4 cycles with data 0xA0..0xA3 -> o_read_data_valid for 4 cycles with the same data, each one cycle later.
- Assert reset mid-write burst -> all outputs 0 asynchronously; after release with calib = 1, a pending read is granted first.
